if_agc: RTL and testbench

Automatic gain controller for the 455 kHz IF filter. It watches the filter's 6-bit signed output, measures the peak magnitude over fixed windows, and steps the filter's 2-bit gain select up or down to hold the signal between two thresholds. After each gain change it holds off while the filter output settles. A manual mode passes a register-supplied gain straight through, and a saturating clip counter gives the SPI block a level indicator.

---
 rtl/if_agc_pkg.sv | 13 +
 rtl/if_peak_detect.sv | 24 ++
 rtl/if_agc.sv | 107 ++++++++++
 tb/tb_if_agc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/if_agc_pkg.sv
// if_agc_pkg: shared state encoding and sample/gain limits for the IF AGC
package if_agc_pkg;
    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        MEASURE = 2'd1,
        DECIDE  = 2'd2,
        HOLD    = 2'd3
    } agc_state_e;
    localparam logic [1:0] GAIN_MIN = 2'd0;
    localparam logic [1:0] GAIN_MAX = 2'd3;
    localparam logic signed [5:0] CLIP_POS = 6'sb011111;
    localparam logic signed [5:0] CLIP_NEG = 6'sb100000;
endpackage

// File: rtl/if_peak_detect.sv
// if_peak_detect: sample magnitude, running peak with clear, and clip flag
module if_peak_detect import if_agc_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [5:0] sample,
    input  logic              en,
    input  logic              clear,
    output logic [5:0]        peak,
    output logic              clip
);
    logic [5:0] mag, peak_d, peak_q;
    // magnitude (-32 maps to 32 in 6 unsigned bits), clip flag and next peak
    always_comb begin
        mag    = sample[5] ? 6'(-sample) : 6'(sample);
        clip   = (sample == CLIP_POS) || (sample == CLIP_NEG);
        peak_d = clear ? '0 : (en && mag > peak_q) ? mag : peak_q;
    end
    // peak register
    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end
    assign peak = peak_q;
endmodule

// File: rtl/if_agc.sv
// if_agc: windowed-peak AGC stepping the IF filter gain, with manual mode and clip counter
module if_agc import if_agc_pkg::*; #(
    parameter int unsigned WIN_LOG2    = 10,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned HI_THRESH   = 28,
    parameter int unsigned LO_THRESH   = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic signed [5:0] if_filt_in,
    input  logic              agc_en,
    input  logic [1:0]        manual_gain,
    input  logic              clip_clr,
    output logic [1:0]        gain_out,
    output logic              gain_changed,
    output logic [7:0]        clip_count,
    output logic [1:0]        agc_state
);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [5:0] HI = 6'(HI_THRESH);
    localparam logic [5:0] LO = 6'(LO_THRESH);

    agc_state_e state_d, state_q;
    logic [WIN_LOG2-1:0] win_d, win_q;
    logic [HW-1:0] hold_d, hold_q;
    logic [1:0] gain_d, gain_q;
    logic changed_d, changed_q;
    logic [7:0] clip_d, clip_q;
    logic [5:0] peak;
    logic clip, pk_en, pk_clr;

    if_peak_detect u_peak (
        .clk    (clk),
        .rst    (RST),
        .sample (if_filt_in),
        .en     (pk_en),
        .clear  (pk_clr),
        .peak   (peak),
        .clip   (clip)
    );

    // FSM next state, window/hold counting and gain decision; dropping agc_en always wins
    always_comb begin
        state_d   = state_q;
        win_d     = '0;
        hold_d    = '0;
        gain_d    = gain_q;
        changed_d = 1'b0;
        pk_en     = 1'b0;
        pk_clr    = 1'b1;
        if (!agc_en) begin
            state_d = MANUAL;
            gain_d  = manual_gain;
        end else begin
            case (state_q)
                MANUAL: begin
                    state_d = MEASURE;
                    gain_d  = manual_gain;
                end
                MEASURE: begin
                    pk_en   = 1'b1;
                    pk_clr  = 1'b0;
                    win_d   = win_q + 1'b1;
                    state_d = (win_q == WIN_LAST) ? DECIDE : MEASURE;
                end
                DECIDE: begin
                    if (peak >= HI && gain_q != GAIN_MIN)      gain_d = gain_q - 1'b1;
                    else if (peak < LO && gain_q != GAIN_MAX)  gain_d = gain_q + 1'b1;
                    changed_d = (gain_d != gain_q);
                    state_d   = changed_d ? HOLD : MEASURE;
                end
                HOLD: begin
                    hold_d  = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
                    state_d = (hold_q == HOLD_LAST) ? MEASURE : HOLD;
                end
                default: state_d = MANUAL;
            endcase
        end
        clip_d = clip_clr ? '0 : (clip && clip_q != 8'hff) ? clip_q + 1'b1 : clip_q;
    end

    // state, counters, gain, pulse and clip count registers
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= MANUAL;
            win_q     <= '0;
            hold_q    <= '0;
            gain_q    <= GAIN_MIN;
            changed_q <= 1'b0;
            clip_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            gain_q    <= gain_d;
            changed_q <= changed_d;
            clip_q    <= clip_d;
        end
    end

    assign gain_out     = gain_q;
    assign gain_changed = changed_q;
    assign clip_count   = clip_q;
    assign agc_state    = state_q;
endmodule

// File: tb/tb_if_agc.sv
// tb_if_agc: directed checks of manual mode, AGC stepping, hold, clip counter and reset
module tb_if_agc;
    logic clk = 1'b0;
    logic RST = 1'b1;
    logic agc_en = 1'b0;
    logic clip_clr = 1'b0;
    logic signed [5:0] if_filt_in = '0;
    logic [1:0] manual_gain = '0;
    logic [1:0] gain_out, agc_state;
    logic gain_changed;
    logic [7:0] clip_count;
    int n_chk = 0;
    int n_fail = 0;
    int n_pulse = 0;

    always #5 clk = ~clk;

    if_agc #(.WIN_LOG2(4), .HOLD_CYCLES(8), .HI_THRESH(28), .LO_THRESH(8)) dut (
        .clk          (clk),
        .RST          (RST),
        .if_filt_in   (if_filt_in),
        .agc_en       (agc_en),
        .manual_gain  (manual_gain),
        .clip_clr     (clip_clr),
        .gain_out     (gain_out),
        .gain_changed (gain_changed),
        .clip_count   (clip_count),
        .agc_state    (agc_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (gain_changed) n_pulse++;
        end
    endtask

    initial begin
        manual_gain = 2'd2;
        run(3);
        check("rst_gain", gain_out, 0);
        check("rst_state", agc_state, 0);
        check("rst_changed", gain_changed, 0);
        check("rst_clip", clip_count, 0);
        RST = 1'b0;
        n_pulse = 0;
        run(1);
        check("man_gain", gain_out, 2);
        check("man_state", agc_state, 0);
        manual_gain = 2'd1;
        check("man_lag", gain_out, 2);
        run(1);
        check("man_follow", gain_out, 1);
        check("man_no_pulse", n_pulse, 0);

        agc_en = 1'b1;
        if_filt_in = 6'sd30;
        run(1);
        check("hi_enter_state", agc_state, 1);
        check("hi_enter_gain", gain_out, 1);
        n_pulse = 0;
        run(16);
        check("hi_decide_state", agc_state, 2);
        check("hi_pre_gain", gain_out, 1);
        check("hi_pre_pulse", n_pulse, 0);
        run(1);
        check("hi_gain", gain_out, 0);
        check("hi_pulse", gain_changed, 1);
        check("hi_hold_state", agc_state, 3);
        run(1);
        check("hi_pulse_end", gain_changed, 0);
        run(7);
        check("hi_hold_done", agc_state, 1);
        n_pulse = 0;
        run(17);
        check("hi_sat_gain", gain_out, 0);
        check("hi_sat_pulse", n_pulse, 0);
        check("hi_sat_state", agc_state, 1);

        agc_en = 1'b0;
        manual_gain = 2'd0;
        if_filt_in = 6'sd3;
        run(1);
        check("lo_manual_gain", gain_out, 0);
        agc_en = 1'b1;
        run(1);
        n_pulse = 0;
        run(16);
        check("lo_pre_gain", gain_out, 0);
        run(1);
        check("lo_step1_gain", gain_out, 1);
        check("lo_step1_pulse", gain_changed, 1);
        for (int g = 2; g <= 3; g++) begin
            run(24);
            check("lo_hold_gain", gain_out, g - 1);
            run(1);
            check("lo_step_gain", gain_out, g);
            check("lo_step_pulse", gain_changed, 1);
        end
        check("lo_pulse_count", n_pulse, 3);
        run(25);
        check("lo_sat_gain", gain_out, 3);
        check("lo_sat_pulse", n_pulse, 3);
        check("lo_sat_state", agc_state, 1);

        clip_clr = 1'b1;
        run(1);
        clip_clr = 1'b0;
        check("clip_zero", clip_count, 0);
        for (int i = 0; i < 20; i++) begin
            if_filt_in = (i % 2 == 0) ? 6'sb100000 : 6'sd0;
            run(1);
        end
        check("clip_alt", clip_count, 10);
        if_filt_in = 6'sd31;
        run(600);
        check("clip_sat", clip_count, 255);
        clip_clr = 1'b1;
        run(1);
        check("clip_clr_prio", clip_count, 0);
        clip_clr = 1'b0;
        run(1);
        check("clip_after_clr", clip_count, 1);

        agc_en = 1'b0;
        manual_gain = 2'd1;
        if_filt_in = 6'sd30;
        run(1);
        agc_en = 1'b1;
        run(1);
        check("drop_enter_gain", gain_out, 1);
        run(17);
        check("drop_dec_gain", gain_out, 0);
        check("drop_dec_pulse", gain_changed, 1);
        run(2);
        check("drop_in_hold", agc_state, 3);
        agc_en = 1'b0;
        manual_gain = 2'd3;
        run(1);
        check("drop_state", agc_state, 0);
        check("drop_gain", gain_out, 3);
        agc_en = 1'b1;
        run(1);
        check("reen_state", agc_state, 1);
        check("reen_gain", gain_out, 3);
        n_pulse = 0;
        run(16);
        check("reen_pre_gain", gain_out, 3);
        check("reen_pre_pulse", n_pulse, 0);
        run(1);
        check("reen_gain_dec", gain_out, 2);
        check("reen_pulse", gain_changed, 1);

        agc_en = 1'b0;
        manual_gain = 2'd1;
        run(1);
        agc_en = 1'b1;
        if_filt_in = 6'sd30;
        run(9);
        check("mid_state", agc_state, 1);
        RST = 1'b1;
        run(1);
        check("mrst_gain", gain_out, 0);
        check("mrst_state", agc_state, 0);
        check("mrst_changed", gain_changed, 0);
        check("mrst_clip", clip_count, 0);
        run(1);
        check("mrst_hold_state", agc_state, 0);
        RST = 1'b0;
        if_filt_in = 6'sd10;
        run(1);
        check("post_state", agc_state, 1);
        check("post_gain", gain_out, 1);
        n_pulse = 0;
        run(17);
        check("post_dec_gain", gain_out, 1);
        check("post_dec_pulse", n_pulse, 0);
        check("post_dec_state", agc_state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
